// File: rtl/led_page_viewer.sv
// Board display front end: input conditioning, debounced hold key,
// and manual/auto paging of a wide result word onto an LED bank.
module led_page_viewer #(
  parameter int DATA_W          = 32,
  parameter int LED_W           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCROLL_CYCLES   = 25000000,
  localparam int PAGES = DATA_W / LED_W,
  localparam int SEL_W = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  sel_async,
  input  logic              mode_async,
  input  logic              hold_key_async,
  output logic [LED_W-1:0]  led,
  output logic [SEL_W-1:0]  page_idx,
  output logic              held,
  output logic              press_pulse
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

  logic [SYNC_STAGES-1:0][SEL_W-1:0] sel_sync;
  logic [SYNC_STAGES-1:0]            mode_sync;
  logic [SYNC_STAGES-1:0]            key_sync;
  logic [SEL_W-1:0]                  sel_s;
  logic                              mode_s;
  logic                              key_s;

  logic          deb;
  logic          deb_d;
  logic [DW-1:0] cnt;

  logic              mode_q;
  logic [TW-1:0]     timer;
  logic [DATA_W-1:0] snapshot;

  logic              press;
  logic              held_n;
  logic [DATA_W-1:0] snap_n;
  logic [DATA_W-1:0] src;
  logic [SEL_W-1:0]  sel_c;
  logic [SEL_W-1:0]  page_n;
  logic [TW-1:0]     timer_n;
  logic [LED_W-1:0]  led_n;

  assign sel_s  = sel_sync[SYNC_STAGES-1];
  assign mode_s = mode_sync[SYNC_STAGES-1];
  assign key_s  = key_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_sync  <= '0;
      mode_sync <= '0;
      key_sync  <= '1;
    end else begin
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], sel_async};
      mode_sync <= {mode_sync[SYNC_STAGES-2:0], mode_async};
      key_sync  <= {key_sync[SYNC_STAGES-2:0], hold_key_async};
    end
  end

  // Key state only moves after an unbroken run of differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
    end else begin
      deb_d <= deb;
      if (key_s == deb) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= key_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

  always_comb begin
    press   = deb_d & ~deb;
    held_n  = held ^ press;
    snap_n  = snapshot;
    if (press && !held) snap_n = data_in;
    src     = held_n ? snap_n : data_in;
    sel_c   = sel_s;
    if (int'(sel_s) >= PAGES) sel_c = SEL_W'(PAGES - 1);
    page_n  = sel_c;
    timer_n = '0;
    // First auto cycle keeps the current page with a fresh timer
    if (mode_s) begin
      page_n = page_idx;
      if (mode_q) begin
        if (timer == TW'(SCROLL_CYCLES - 1)) begin
          if (int'(page_idx) == PAGES - 1) page_n = '0;
          else page_n = page_idx + SEL_W'(1);
        end else begin
          timer_n = timer + TW'(1);
        end
      end
    end
    led_n = src[int'(page_n)*LED_W +: LED_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led         <= '0;
      page_idx    <= '0;
      held        <= 1'b0;
      press_pulse <= 1'b0;
      snapshot    <= '0;
      timer       <= '0;
      mode_q      <= 1'b0;
    end else begin
      led         <= led_n;
      page_idx    <= page_n;
      held        <= held_n;
      press_pulse <= press;
      snapshot    <= snap_n;
      timer       <= timer_n;
      mode_q      <= mode_s;
    end
  end

endmodule

// File: tb/tb_led_page_viewer.sv
// Directed bench for led_page_viewer: paging table, debounce,
// hold, auto-scroll and mid-operation reset sequences.
module tb_led_page_viewer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [1:0]  sel_async;
  logic        mode_async;
  logic        hold_key_async;
  logic [7:0]  led;
  logic [1:0]  page_idx;
  logic        held;
  logic        press_pulse;

  int errors = 0;
  int checks = 0;

  led_page_viewer #(
    .DATA_W(32),
    .LED_W(8),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .SCROLL_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .sel_async(sel_async),
    .mode_async(mode_async),
    .hold_key_async(hold_key_async),
    .led(led),
    .page_idx(page_idx),
    .held(held),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [7:0]  led;
  } vec_t;

  vec_t vt[8];

  logic       obs_held[1:16];
  logic       obs_pp[1:16];
  logic [7:0] obs_led[1:16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] d,
                                         input int p);
    return d[p*8 +: 8];
  endfunction

  task automatic run_key(input int low_n);
    hold_key_async = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      obs_held[c] = held;
      obs_pp[c]   = press_pulse;
      obs_led[c]  = led;
      if (c == low_n) hold_key_async = 1'b1;
    end
  endtask

  function automatic int pulses();
    int n = 0;
    for (int c = 1; c <= 16; c++) if (obs_pp[c]) n++;
    return n;
  endfunction

  initial begin
    logic [1:0] prev_sel;
    int         exp_pg;
    bit         found;
    int         npp;

    vt[0] = '{2'd0, 32'hDEADBEEF, 8'hEF};
    vt[1] = '{2'd1, 32'hDEADBEEF, 8'hBE};
    vt[2] = '{2'd2, 32'hDEADBEEF, 8'hAD};
    vt[3] = '{2'd3, 32'hDEADBEEF, 8'hDE};
    vt[4] = '{2'd2, 32'h12345678, 8'h34};
    vt[5] = '{2'd1, 32'h12345678, 8'h56};
    vt[6] = '{2'd0, 32'h0A0B0C0D, 8'h0D};
    vt[7] = '{2'd3, 32'h0A0B0C0D, 8'h0A};

    rst = 1'b1;
    data_in = 32'h0;
    sel_async = 2'd0;
    mode_async = 1'b0;
    hold_key_async = 1'b1;
    cyc(2);
    chk("reset_led", led, 0);
    chk("reset_page", page_idx, 0);
    chk("reset_held", held, 0);
    chk("reset_press", press_pulse, 0);
    rst = 1'b0;

    data_in = 32'hDEADBEEF;
    sel_async = 2'd3;
    cyc(4);
    prev_sel = 2'd3;

    for (int i = 0; i < 8; i++) begin
      sel_async = vt[i].sel;
      data_in = vt[i].data;
      cyc(2);
      chk($sformatf("latency_old_page[%0d]", i), led,
          byte_of(vt[i].data, prev_sel));
      cyc(1);
      chk($sformatf("table_led[%0d]", i), led, vt[i].led);
      chk($sformatf("table_page[%0d]", i), page_idx, vt[i].sel);
      prev_sel = vt[i].sel;
    end

    data_in = 32'h12345678;
    sel_async = 2'd0;
    cyc(4);
    run_key(3);
    chk("glitch_pulses", pulses(), 0);
    chk("glitch_held", obs_held[16], 0);

    run_key(6);
    chk("press_held_before", obs_held[6], 0);
    chk("press_held_after", obs_held[7], 1);
    chk("press_pulse_cycle", obs_pp[7], 1);
    chk("press_pulse_count", pulses(), 1);

    data_in = 32'hFFFFFFFF;
    cyc(2);
    chk("hold_led_p0", led, 8'h78);
    chk("hold_held", held, 1);
    sel_async = 2'd1;
    cyc(3);
    chk("hold_led_p1", led, 8'h56);
    sel_async = 2'd0;
    cyc(3);

    run_key(6);
    chk("unhold_before", obs_held[6], 1);
    chk("unhold_after", obs_held[7], 0);
    chk("unhold_pulse", obs_pp[7], 1);
    chk("unhold_led", obs_led[8], 8'hFF);

    data_in = 32'hDEADBEEF;
    sel_async = 2'd2;
    cyc(4);
    chk("auto_start_page", page_idx, 2);
    mode_async = 1'b1;
    sel_async = 2'd0;
    for (int c = 1; c <= 40; c++) begin
      cyc(1);
      exp_pg = (c < 11) ? 2 : (2 + (c - 11) / 8 + 1) % 4;
      chk($sformatf("auto_page[%0d]", c), page_idx, exp_pg);
      chk($sformatf("auto_led[%0d]", c), led,
          byte_of(32'hDEADBEEF, exp_pg));
    end

    mode_async = 1'b0;
    sel_async = 2'd1;
    cyc(3);
    chk("manual_return_page", page_idx, 1);
    chk("manual_return_led", led, 8'hBE);

    data_in = 32'hCAFEBABE;
    run_key(6);
    chk("pre_rst_held", obs_held[16], 1);
    mode_async = 1'b1;
    data_in = 32'h0;
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      cyc(1);
      if (page_idx == 2'd3) found = 1'b1;
    end
    chk("wait_page3", found, 1);
    chk("snapshot_page3", led, 8'hCA);
    hold_key_async = 1'b0;
    cyc(3);
    chk("pre_rst_page", page_idx, 3);
    chk("pre_rst_held2", held, 1);
    rst = 1'b1;
    hold_key_async = 1'b1;
    cyc(1);
    chk("midrst_led", led, 0);
    chk("midrst_page", page_idx, 0);
    chk("midrst_held", held, 0);
    chk("midrst_press", press_pulse, 0);
    rst = 1'b0;
    mode_async = 1'b0;
    sel_async = 2'd0;
    data_in = 32'h11223344;
    npp = 0;
    for (int c = 1; c <= 16; c++) begin
      cyc(1);
      if (press_pulse) npp++;
    end
    chk("post_rst_pulses", npp, 0);
    chk("post_rst_held", held, 0);
    chk("post_rst_led", led, 8'h44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_page_viewer.md
Name: led_page_viewer

Overview:
- Parametrised board-level display front end. Conditions raw switch/key inputs and pages a wide result word onto a narrow LED bank.
- Adds features the fixed 2-bit byte selector lacks: configurable widths and sync depth, a debounced hold key that freezes a snapshot of the result, and an auto-scroll mode that cycles through pages on a timer.
- Sits between the compute core's result bus and the board LEDs.

Parameters:
- DATA_W, 32, width of the result word; must be an integer multiple of LED_W.
- LED_W, 8, LED bank width; the page size.
- SYNC_STAGES, 2, flip-flop depth of every input synchronizer; minimum 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before the hold key changes state (20 ms at 50 MHz).
- SCROLL_CYCLES, 25000000, cycles per page in auto-scroll mode.
- PAGES (derived, not overridable), DATA_W/LED_W.
- SEL_W (derived), max(1, $clog2(PAGES)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active high.
- data_in  in  DATA_W  live result word; already in the clk domain, not synchronized.
- sel_async  in  SEL_W  raw page-select switches.
- mode_async  in  1  raw switch; 1 = auto-scroll, 0 = manual.
- hold_key_async  in  1  raw pushbutton, active low (0 = pressed).
- led  out  LED_W  selected page of the display source.
- page_idx  out  SEL_W  page currently driven on led.
- held  out  1  1 while the display shows the frozen snapshot.
- press_pulse  out  1  one-cycle pulse on each debounced press.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - led=0, page_idx=0, held=0, press_pulse=0, snapshot=0.
  - Scroll timer=0, debounce counter=0.
  - Debounced key state=1 (released).
  - Key sync chain resets to 1; sel and mode chains reset to 0.
- Synchronizers: SYNC_STAGES-deep chain on each bit of sel_async, mode_async and hold_key_async. Synchronized signals are sel_s, mode_s and key_s.
- Debounce:
  - The counter increments while key_s differs from the debounced state. It clears whenever key_s equals the debounced state.
  - When the count reaches DEBOUNCE_CYCLES-1 while key_s still differs, the debounced state takes key_s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes state.
- Press: press_pulse=1 for exactly one cycle when the debounced state goes 1->0. The release (0->1) produces no pulse.
- Hold toggle:
  - A press with held=0 sets held=1 and loads snapshot<=data_in in that same cycle.
  - A press with held=1 clears held. The snapshot keeps its value.
- Display source: src = held ? snapshot : data_in.
- Page selection, manual mode (mode_s=0):
  - Target page = sel_s, clamped to PAGES-1 if sel_s >= PAGES.
  - The scroll timer is held at 0.
- Page selection, auto mode (mode_s=1):
  - On the first cycle with mode_s=1 (0->1 edge), the page starts at the current page_idx and the timer is 0.
  - The timer counts 0..SCROLL_CYCLES-1. On the terminal count, the page advances by 1, wrapping PAGES-1 -> 0, and the timer returns to 0.
  - sel_s is ignored in this mode.
- Auto to manual (1->0): page_idx takes the clamped sel_s on the next register update.
- Output register:
  - led <= src[page*LED_W +: LED_W] and page_idx <= page, both updated every cycle.
  - led and page_idx always agree with each other.
- Latency:
  - data_in -> led: 1 cycle (when not held).
  - sel_async -> led: SYNC_STAGES+1 cycles.
  - hold_key_async -> held: SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous events: a press and a scroll terminal count in the same cycle are both applied. The led value after that edge is taken from the new src and the new page.
- Reset mid-operation: all state returns to reset values on the next edge. Any held snapshot is lost, and a press already being debounced is discarded.
- PAGES=1: page_idx is constantly 0; auto mode has no visible effect.

Test Plan:
- Bench parameters: DATA_W=32, LED_W=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, SCROLL_CYCLES=8.
- Manual paging: data_in=32'hDEADBEEF, sel_async stepped 0,1,2,3 -> led = EF, BE, AD, DE, each appearing 3 cycles after the sel change; page_idx matches.
- Debounce: key pulled low for 3 cycles then high -> no press_pulse, held stays 0. Key low for 6 cycles -> exactly one press_pulse; held=1 at SYNC_STAGES+5 cycles after the fall.
- Hold:
  - data_in=32'h12345678 at the press, then changed to 32'hFFFFFFFF -> led stays 78 at sel=0 while held.
  - A second debounced press -> led=FF one cycle after held clears.
- Auto-scroll:
  - mode=1 with page 2 selected -> page_idx goes 2,3,0,1,2, advancing every 8 cycles; wrap observed.
  - mode=0 with sel=1 -> page_idx returns to 1.
- Reset mid-operation: assert rst while held=1 in auto mode at page 3 -> next edge shows led=0, page_idx=0, held=0, snapshot=0; a key press in flight before rst yields no press_pulse afterwards.
